// File: rtl/ram_port_arbiter_if.sv
// Bundle of the two line requesters and the 16-bit RAM port seen by ram_port_arbiter.
// slave = the arbiter's view; master = the cache controllers plus the RAM.
interface ram_port_arbiter_if #(
    parameter int RAM_ADDR_SIZE   = 13,
    parameter int RAM_WORD_SIZE   = 16,
    parameter int CACHE_STR_WIDTH = 64
);
    logic                       m0_req, m1_req;
    logic [RAM_ADDR_SIZE-1:0]   m0_addr, m1_addr;
    logic                       m0_rnw, m1_rnw;
    logic [CACHE_STR_WIDTH-1:0] m0_wdata, m1_wdata;
    logic                       m0_done, m1_done;
    logic                       m0_err, m1_err;
    logic [CACHE_STR_WIDTH-1:0] m0_rdata, m1_rdata;
    logic [RAM_ADDR_SIZE-1:0]   ram_addr;
    logic [RAM_WORD_SIZE-1:0]   ram_wdata;
    logic                       ram_avalid;
    logic                       ram_rnw;
    logic [RAM_WORD_SIZE-1:0]   ram_rdata;
    logic                       ram_ack;

    modport slave (
        input  m0_req, m1_req, m0_addr, m1_addr, m0_rnw, m1_rnw, m0_wdata, m1_wdata,
        input  ram_rdata, ram_ack,
        output m0_done, m1_done, m0_err, m1_err, m0_rdata, m1_rdata,
        output ram_addr, ram_wdata, ram_avalid, ram_rnw
    );

    modport master (
        output m0_req, m1_req, m0_addr, m1_addr, m0_rnw, m1_rnw, m0_wdata, m1_wdata,
        output ram_rdata, ram_ack,
        input  m0_done, m1_done, m0_err, m1_err, m0_rdata, m1_rdata,
        input  ram_addr, ram_wdata, ram_avalid, ram_rnw
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// Round-robin sharing of one 16-bit RAM port between two line requesters; each
// 64-bit line moves as 4 beats (beat 0 = bits [15:0]) with an ack timeout.
module ram_port_arbiter #(
    parameter int RAM_ADDR_SIZE   = 13,
    parameter int RAM_WORD_SIZE   = 16,
    parameter int CACHE_STR_WIDTH = 64,
    parameter int TIMEOUT         = 255
) (
    input logic              ram_clk,
    input logic              ram_rst,
    ram_port_arbiter_if.slave bus
);
    localparam int BEATS = CACHE_STR_WIDTH / RAM_WORD_SIZE;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int TW    = $clog2(TIMEOUT + 1);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] CMD   = 3'd1;
    localparam logic [2:0] WBEAT = 3'd2;
    localparam logic [2:0] WACK  = 3'd3;
    localparam logic [2:0] RBEAT = 3'd4;
    localparam logic [2:0] DONE  = 3'd5;

    logic [2:0]                 state;
    logic                       grant, last_grant, win;
    logic [RAM_ADDR_SIZE-1:0]   addr_q;
    logic                       rnw_q, err_q;
    logic [CACHE_STR_WIDTH-1:0] line;
    logic [CACHE_STR_WIDTH-1:0] rdata0_q, rdata1_q;
    logic [CW-1:0]              cnt;
    logic [TW-1:0]              tmo;
    logic                       tmo_hit, last_beat, copy_rd;

    // With both requesting, the port that did not win last time goes next.
    assign win       = (bus.m0_req && bus.m1_req) ? ~last_grant : bus.m1_req;
    assign tmo_hit   = !bus.ram_ack && (tmo == TW'(TIMEOUT - 1));
    assign last_beat = (cnt == CW'(BEATS - 1));
    assign copy_rd   = (state == DONE) && rnw_q && !err_q;

    always_ff @(posedge ram_clk) begin
        if (ram_rst) begin
            state      <= IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            addr_q     <= '0;
            rnw_q      <= 1'b0;
            err_q      <= 1'b0;
            line       <= '0;
            cnt        <= '0;
            tmo        <= '0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
        end else begin
            case (state)
                IDLE: if (bus.m0_req || bus.m1_req) begin
                    grant      <= win;
                    last_grant <= win;
                    addr_q     <= win ? bus.m1_addr  : bus.m0_addr;
                    rnw_q      <= win ? bus.m1_rnw   : bus.m0_rnw;
                    line       <= win ? bus.m1_wdata : bus.m0_wdata;
                    err_q      <= 1'b0;
                    tmo        <= '0;
                    state      <= CMD;
                end
                CMD: begin
                    // Beat 0 of a write already went out alongside the command.
                    cnt   <= rnw_q ? CW'(0) : CW'(1);
                    tmo   <= '0;
                    state <= rnw_q ? RBEAT : WBEAT;
                end
                WBEAT: begin
                    cnt <= cnt + 1'b1;
                    if (last_beat) state <= WACK;
                end
                WACK: begin
                    if (bus.ram_ack) begin
                        tmo   <= '0;
                        state <= DONE;
                    end else if (tmo_hit) begin
                        err_q <= 1'b1;
                        state <= DONE;
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                end
                RBEAT: begin
                    if (bus.ram_ack) begin
                        line[cnt*RAM_WORD_SIZE +: RAM_WORD_SIZE] <= bus.ram_rdata;
                        cnt <= cnt + 1'b1;
                        tmo <= '0;
                        if (last_beat) state <= DONE;
                    end else if (tmo_hit) begin
                        err_q <= 1'b1;
                        state <= DONE;
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                end
                DONE: begin
                    if (copy_rd && !grant) rdata0_q <= line;
                    if (copy_rd &&  grant) rdata1_q <= line;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        bus.ram_wdata = '0;
        if (state == CMD)   bus.ram_wdata = line[RAM_WORD_SIZE-1:0];
        if (state == WBEAT) bus.ram_wdata = line[cnt*RAM_WORD_SIZE +: RAM_WORD_SIZE];
    end

    assign bus.ram_avalid = (state == CMD);
    assign bus.ram_addr   = (state != IDLE) ? addr_q : '0;
    assign bus.ram_rnw    = (state != IDLE) && rnw_q;

    assign bus.m0_done = (state == DONE) && !grant;
    assign bus.m1_done = (state == DONE) &&  grant;
    assign bus.m0_err  = bus.m0_done && err_q;
    assign bus.m1_err  = bus.m1_done && err_q;

    // The assembled line is visible during the done pulse, then held in the register.
    assign bus.m0_rdata = (copy_rd && !grant) ? line : rdata0_q;
    assign bus.m1_rdata = (copy_rd &&  grant) ? line : rdata1_q;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: behavioural RAM with per-beat ack gaps,
// a negedge monitor for done/avalid timing, and one task per scenario.
module tb_ram_port_arbiter;
    localparam int A = 13, R = 16, W = 64, TIMEOUT = 255;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ram_port_arbiter_if #(.RAM_ADDR_SIZE(A), .RAM_WORD_SIZE(R), .CACHE_STR_WIDTH(W)) bus ();

    ram_port_arbiter #(.RAM_ADDR_SIZE(A), .RAM_WORD_SIZE(R), .CACHE_STR_WIDTH(W),
                       .TIMEOUT(TIMEOUT)) dut (
        .ram_clk(clk),
        .ram_rst(rst),
        .bus    (bus)
    );

    // RAM model state
    logic [W-1:0]        mem [0:8191];
    int                  gap [4];
    int                  n_acks;
    logic [3:0][R-1:0]   wlog;
    logic [3:0][A-1:0]   wadr;
    logic [3:0]          wav;

    initial begin
        logic [A-1:0] a;
        logic [W-1:0] l;
        bus.ram_ack   = 1'b0;
        bus.ram_rdata = '0;
        forever begin
            @(negedge clk);
            if (bus.ram_avalid && !rst) begin
                a = bus.ram_addr;
                if (bus.ram_rnw) begin
                    l = mem[a];
                    @(posedge clk); #1;
                    for (int i = 0; i < n_acks; i++) begin
                        repeat (gap[i]) begin @(posedge clk); #1; end
                        bus.ram_ack   = 1'b1;
                        bus.ram_rdata = l[i*R +: R];
                        @(posedge clk); #1;
                        bus.ram_ack   = 1'b0;
                        bus.ram_rdata = '0;
                    end
                end else begin
                    wlog[0] = bus.ram_wdata; wadr[0] = bus.ram_addr; wav[0] = bus.ram_avalid;
                    for (int i = 1; i < 4; i++) begin
                        @(negedge clk);
                        wlog[i] = bus.ram_wdata; wadr[i] = bus.ram_addr; wav[i] = bus.ram_avalid;
                    end
                    mem[a] = wlog;
                    @(posedge clk); #1;
                    bus.ram_ack = 1'b1;
                    @(posedge clk); #1;
                    bus.ram_ack = 1'b0;
                end
            end
        end
    end

    // Monitor: event counts/cycles, plus the req-held-until-done protocol assertion.
    int           av_cnt = 0, av_cyc = 0, ack_cyc = 0;
    int           done0_cnt = 0, done1_cnt = 0, done0_cyc = 0, done1_cyc = 0;
    int           err0_cnt = 0, err1_cnt = 0;
    bit           err0_at_done, av_rnw, pend0, pend1;
    logic [A-1:0] av_addr;
    int           order [$];

    always @(negedge clk) begin
        if (rst) begin
            pend0 = 1'b0;
            pend1 = 1'b0;
        end else begin
            assert (!(pend0 && !bus.m0_req)) else begin
                $display("FAIL req_drop_m0 got req=0 exp req=1 before done"); fails++;
            end
            assert (!(pend1 && !bus.m1_req)) else begin
                $display("FAIL req_drop_m1 got req=0 exp req=1 before done"); fails++;
            end
            pend0 = bus.m0_req && !bus.m0_done;
            pend1 = bus.m1_req && !bus.m1_done;
        end
        if (bus.m0_done === 1'b1) begin
            done0_cnt++; done0_cyc = cyc; err0_at_done = bus.m0_err; order.push_back(0);
        end
        if (bus.m1_done === 1'b1) begin
            done1_cnt++; done1_cyc = cyc; order.push_back(1);
        end
        if (bus.m0_err === 1'b1) err0_cnt++;
        if (bus.m1_err === 1'b1) err1_cnt++;
        if (bus.ram_avalid === 1'b1) begin
            av_cnt++; av_cyc = cyc; av_rnw = bus.ram_rnw; av_addr = bus.ram_addr;
        end
        if (bus.ram_ack === 1'b1) ack_cyc = cyc;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got no end of run exp finish");
        $fatal(1);
    end

    // Waits (bounded) for done on each wanted port, dropping each req after its done.
    task automatic serve(input bit w0, input bit w1, input int budget, output bit ok);
        bit s0 = !w0, s1 = !w1, d0, d1;
        int n = 0;
        while (!(s0 && s1) && n < budget) begin
            @(negedge clk);
            n++;
            d0 = bus.m0_done;
            d1 = bus.m1_done;
            @(posedge clk); #1;
            if (d0 && !s0) begin s0 = 1'b1; bus.m0_req = 1'b0; end
            if (d1 && !s1) begin s1 = 1'b1; bus.m1_req = 1'b0; end
        end
        ok = s0 && s1;
    endtask

    task automatic req0(input logic [A-1:0] a, input bit rnw, input logic [W-1:0] wd);
        bus.m0_addr = a; bus.m0_rnw = rnw; bus.m0_wdata = wd; bus.m0_req = 1'b1;
    endtask

    task automatic req1(input logic [A-1:0] a, input bit rnw, input logic [W-1:0] wd);
        bus.m1_addr = a; bus.m1_rnw = rnw; bus.m1_wdata = wd; bus.m1_req = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        tests++;
        if ({bus.ram_avalid, bus.ram_rnw, bus.m0_done, bus.m1_done, bus.m0_err, bus.m1_err} !== 6'b0) begin
            $display("FAIL reset_ctrl got %b exp 000000", {bus.ram_avalid, bus.ram_rnw,
                     bus.m0_done, bus.m1_done, bus.m0_err, bus.m1_err}); fails++;
        end
        tests++;
        if (bus.ram_addr !== 13'h0) begin
            $display("FAIL reset_addr got %h exp 0", bus.ram_addr); fails++;
        end
        tests++;
        if (bus.ram_wdata !== 16'h0) begin
            $display("FAIL reset_wdata got %h exp 0", bus.ram_wdata); fails++;
        end
        tests++;
        if ({bus.m0_rdata, bus.m1_rdata} !== 128'h0) begin
            $display("FAIL reset_rdata got %h %h exp 0", bus.m0_rdata, bus.m1_rdata); fails++;
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_contention();
        bit ok;
        logic [3:0] got;
        order.delete();
        for (int r = 0; r < 2; r++) begin
            req0(13'h0202, 1'b1, '0);
            req1(13'h0303, 1'b1, '0);
            serve(1'b1, 1'b1, 100, ok);
            tests++;
            if (!ok) begin $display("FAIL contention_done round %0d got timeout exp both done", r); fails++; end
        end
        got = 4'hf;
        if (order.size() == 4) got = {order[0][0], order[1][0], order[2][0], order[3][0]};
        tests++;
        if (got !== 4'b0101 || order.size() != 4) begin
            $display("FAIL contention_order got %b (n=%0d) exp 0101", got, order.size()); fails++;
        end
        tests++;
        if (bus.m0_rdata !== 64'h0202_0202_aaaa_5555) begin
            $display("FAIL contention_rdata0 got %h exp 02020202aaaa5555", bus.m0_rdata); fails++;
        end
        tests++;
        if (bus.m1_rdata !== 64'h0303_0303_bbbb_6666) begin
            $display("FAIL contention_rdata1 got %h exp 03030303bbbb6666", bus.m1_rdata); fails++;
        end
    endtask

    task automatic test_single_read();
        bit ok;
        int av0 = av_cnt, d1c = done1_cnt, e0 = err0_cnt, c0;
        req0(13'h0101, 1'b1, '0);
        c0 = cyc;
        serve(1'b1, 1'b0, 100, ok);
        tests++;
        if (!ok) begin $display("FAIL read_done got timeout exp done"); fails++; end
        tests++;
        if (av_cnt - av0 != 1 || av_rnw !== 1'b1 || av_addr !== 13'h0101) begin
            $display("FAIL read_cmd got n=%0d rnw=%b addr=%h exp n=1 rnw=1 addr=0101",
                     av_cnt - av0, av_rnw, av_addr); fails++;
        end
        tests++;
        if (av_cyc - c0 != 1) begin
            $display("FAIL read_cmd_latency got %0d exp 1", av_cyc - c0); fails++;
        end
        tests++;
        if (done0_cyc - ack_cyc != 1) begin
            $display("FAIL read_done_latency got %0d exp 1", done0_cyc - ack_cyc); fails++;
        end
        tests++;
        if (bus.m0_rdata !== 64'h3000_2000_1000_080f) begin
            $display("FAIL read_rdata got %h exp 300020001000080f", bus.m0_rdata); fails++;
        end
        tests++;
        if (done1_cnt != d1c || err0_cnt != e0) begin
            $display("FAIL read_side got m1_done=%0d err=%0d exp 0 0", done1_cnt - d1c, err0_cnt - e0); fails++;
        end
    endtask

    task automatic test_single_write();
        bit ok;
        int d0c = done0_cnt;
        req1(13'h1f07, 1'b0, 64'h3000_2000_1000_f83f);
        serve(1'b0, 1'b1, 100, ok);
        tests++;
        if (!ok) begin $display("FAIL write_done got timeout exp done"); fails++; end
        tests++;
        if (wlog !== 64'h3000_2000_1000_f83f) begin
            $display("FAIL write_beats got %h exp 300020001000f83f", wlog); fails++;
        end
        tests++;
        if (wav !== 4'b0001 || wadr !== {4{13'h1f07}} || av_rnw !== 1'b0) begin
            $display("FAIL write_cmd got avalid=%b addr=%h rnw=%b exp 0001 1f07x4 0", wav, wadr, av_rnw);
            fails++;
        end
        tests++;
        if (mem[13'h1f07] !== 64'h3000_2000_1000_f83f) begin
            $display("FAIL write_mem got %h exp 300020001000f83f", mem[13'h1f07]); fails++;
        end
        tests++;
        if (done1_cyc - ack_cyc != 1 || done0_cnt != d0c) begin
            $display("FAIL write_done_latency got %0d m0_done=%0d exp 1 0", done1_cyc - ack_cyc,
                     done0_cnt - d0c); fails++;
        end
    endtask

    task automatic test_gapped_acks();
        bit ok;
        int e0 = err0_cnt;
        gap = '{0, 0, 3, 1};
        req0(13'h0aaa, 1'b1, '0);
        serve(1'b1, 1'b0, 100, ok);
        gap = '{0, 0, 0, 0};
        tests++;
        if (!ok || bus.m0_rdata !== 64'hdead_beef_1234_5678) begin
            $display("FAIL gapped_rdata got ok=%b %h exp deadbeef12345678", ok, bus.m0_rdata); fails++;
        end
        // acks in cycles av+1, av+2, av+6, av+8 -> done at av+9
        tests++;
        if (done0_cyc - av_cyc != 9 || err0_cnt != e0) begin
            $display("FAIL gapped_timing got %0d err=%0d exp 9 0", done0_cyc - av_cyc, err0_cnt - e0);
            fails++;
        end
    endtask

    task automatic test_timeout();
        bit ok;
        int e0 = err0_cnt, e1 = err1_cnt;
        n_acks = 0;
        req0(13'h0101, 1'b1, '0);
        serve(1'b1, 1'b0, 400, ok);
        n_acks = 4;
        tests++;
        if (!ok || err0_at_done !== 1'b1 || err0_cnt - e0 != 1) begin
            $display("FAIL timeout_err got ok=%b err_at_done=%b n=%0d exp 1 1 1", ok, err0_at_done,
                     err0_cnt - e0); fails++;
        end
        // TIMEOUT waiting cycles follow the avalid cycle, then the done cycle.
        tests++;
        if (done0_cyc - av_cyc != TIMEOUT + 1) begin
            $display("FAIL timeout_latency got %0d exp %0d", done0_cyc - av_cyc, TIMEOUT + 1); fails++;
        end
        tests++;
        if (bus.m0_rdata !== 64'hdead_beef_1234_5678) begin
            $display("FAIL timeout_rdata got %h exp deadbeef12345678", bus.m0_rdata); fails++;
        end
        req1(13'h0303, 1'b1, '0);
        serve(1'b0, 1'b1, 100, ok);
        tests++;
        if (!ok || bus.m1_rdata !== 64'h0303_0303_bbbb_6666 || err1_cnt != e1) begin
            $display("FAIL timeout_recover got ok=%b %h err=%0d exp 1 03030303bbbb6666 0", ok,
                     bus.m1_rdata, err1_cnt - e1); fails++;
        end
    endtask

    task automatic test_reset_mid_read();
        bit ok;
        int av0 = av_cnt, d0c = done0_cnt;
        n_acks = 2;
        req0(13'h0202, 1'b1, '0);
        repeat (4) @(posedge clk);
        #1;
        tests++;
        if (av_cnt - av0 != 1 || bus.ram_addr !== 13'h0202) begin
            $display("FAIL midrst_started got n=%0d addr=%h exp 1 0202", av_cnt - av0, bus.ram_addr);
            fails++;
        end
        rst = 1'b1;
        bus.m0_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if ({bus.ram_avalid, bus.ram_rnw, bus.m0_done, bus.m0_err} !== 4'b0 || bus.ram_addr !== 13'h0
            || bus.ram_wdata !== 16'h0 || bus.m0_rdata !== 64'h0) begin
            $display("FAIL midrst_outputs got ctl=%b addr=%h wd=%h rd=%h exp all 0",
                     {bus.ram_avalid, bus.ram_rnw, bus.m0_done, bus.m0_err}, bus.ram_addr,
                     bus.ram_wdata, bus.m0_rdata); fails++;
        end
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (done0_cnt != d0c) begin
            $display("FAIL midrst_no_done got %0d exp 0", done0_cnt - d0c); fails++;
        end
        n_acks = 4;
        req0(13'h0101, 1'b1, '0);
        serve(1'b1, 1'b0, 100, ok);
        tests++;
        if (!ok || bus.m0_rdata !== 64'h3000_2000_1000_080f) begin
            $display("FAIL midrst_fresh got ok=%b %h exp 1 300020001000080f", ok, bus.m0_rdata);
            fails++;
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.m0_req = 1'b0; bus.m0_addr = '0; bus.m0_rnw = 1'b0; bus.m0_wdata = '0;
        bus.m1_req = 1'b0; bus.m1_addr = '0; bus.m1_rnw = 1'b0; bus.m1_wdata = '0;
        n_acks = 4;
        gap    = '{0, 0, 0, 0};
        mem[13'h0101] = 64'h3000_2000_1000_080f;
        mem[13'h0202] = 64'h0202_0202_aaaa_5555;
        mem[13'h0303] = 64'h0303_0303_bbbb_6666;
        mem[13'h0aaa] = 64'hdead_beef_1234_5678;
        @(posedge clk); #1;
        test_reset();
        test_contention();
        test_single_read();
        test_single_write();
        test_gapped_acks();
        test_timeout();
        test_reset_mid_read();
        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
